// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 serial receiver with mid-bit sampling.
// Synchronises the raw rx pin, times each bit with a down-counting baud
// counter and presents received bytes as single-cycle strobes. Stop-bit
// failures are reported on a separate strobe and the receiver then waits
// for the line to return high before hunting for the next start bit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rxs
// START     | counting half a bit to the middle of the start bit
// DATA      | sampling the eight data bits, LSB first, one per bit period
// STOP      | waiting for mid stop bit; decides byte vs framing error
// WAIT_IDLE | stop bit was low (break); wait for rxs to return high
module uart_rx_sampler #(
  parameter int CLOCKS_PER_BAUD = 33,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);

  // A tick happens when the counter reaches zero, so loading N gives a
  // tick N+1 cycles later: a full period reloads C-1, the half-bit hunt
  // loads floor(C/2)-1.
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF_LOAD   = CW'(CLOCKS_PER_BAUD / 2 - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  logic [CW-1:0] cnt_q;
  logic          tick;
  logic          load_half;

  logic [2:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_d;
  logic       valid_d;
  logic       ferr_d;

  // Input synchroniser; resets to the idle (high) line level so a reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  assign tick = (cnt_q == '0);

  // Baud down-counter: FSM half-bit load wins over the periodic reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_half) begin
      cnt_q <= HALF_LOAD;
    end else if (tick) begin
      cnt_q <= BAUD_RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Next-state, shift register and output strobe decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_o;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    load_half = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          load_half = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rxs) begin
            // Line went back high before mid start bit: treat as noise.
            state_d = ST_IDLE;
          end else begin
            idx_d   = 3'd0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rxs) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            // Returning at mid stop bit leaves half a bit of margin to
            // catch an immediately following start bit.
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Registered outputs; strobes default low so each lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      data_o      <= data_d;
      valid_o     <= valid_d;
      frame_err_o <= ferr_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Testbench for uart_rx_sampler: table of frames plus hand-written corner
// sequences; a scoreboard queue holds expected pulses with their cycle.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  localparam int C   = 33;
  // Cycles from driving the start bit (just after a posedge) to the
  // negedge sample where the strobe is visible.
  localparam int LAT = 1 + 2 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx_sampler #(
    .CLOCKS_PER_BAUD(C),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .data_o(data_o),
    .valid_o(valid_o),
    .frame_err_o(frame_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         p100;
    int         gap;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model_data = 8'h00;
  logic       prev_v = 1'b0;
  logic       prev_e = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (valid_o || frame_err_o) begin
      check("exclusive", int'(valid_o & frame_err_o), 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%02h at cycle %0d, expected no pulse",
                 valid_o, frame_err_o, data_o, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", int'(frame_err_o), int'(mon_e.is_err));
        check("pulse_cycle", cyc, mon_e.cycle);
        check("data_o", int'(data_o), int'(mon_e.data));
      end
    end
    if (prev_v) check("valid_width", int'(valid_o), 0);
    if (prev_e) check("ferr_width", int'(frame_err_o), 0);
    prev_v = valid_o;
    prev_e = frame_err_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic push(input bit err, input logic [7:0] d);
    exp_t e;
    if (!err) model_data = d;
    e.is_err = err;
    e.data   = model_data;
    e.cycle  = cyc + LAT;
    sb.push_back(e);
  endtask

  // Drive one frame; p100 is the sender bit period in hundredths of a clock.
  task automatic send_bits(input logic [7:0] d, input bit stop, input int p100, input int max_cycles);
    int b;
    for (int n = 0; (n * 100 < 10 * p100) && (n < max_cycles); n++) begin
      b = (n * 100) / p100;
      if (b == 0) rx = 1'b0;
      else if (b <= 8) rx = d[b-1];
      else rx = stop;
      tick();
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{8'h55, 3300, 20, 1'b0, 8'h55};
    vecs[1] = '{8'h00, 3300, 40, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 3300, 0,  1'b0, 8'hFF};
    vecs[3] = '{8'hA3, 3300, 0,  1'b0, 8'hA3};
    vecs[4] = '{8'hC5, 3234, 40, 1'b0, 8'hC5};
    vecs[5] = '{8'hC5, 3366, 40, 1'b0, 8'hC5};
    vecs[6] = '{8'h01, 3300, 5,  1'b0, 8'h01};
    vecs[7] = '{8'h80, 3300, 0,  1'b0, 8'h80};

    // Reset state.
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) tick();
    check("rst_data", int'(data_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_ferr", int'(frame_err_o), 0);
    check("rst_busy", int'(busy_o), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", int'(busy_o), 0);

    // Table-driven frames: single, back-to-back and off-rate senders.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].gap > 0) begin
        idle(vecs[i].gap);
        check("busy_before_frame", int'(busy_o), 0);
      end
      push(vecs[i].exp_err, vecs[i].exp_data);
      send_bits(vecs[i].data, 1'b1, vecs[i].p100, 1000);
    end
    drain(LAT + 100);
    idle(5);
    check("busy_after_frames", int'(busy_o), 0);

    // Short low glitch: no output, back to idle quickly.
    rx = 1'b0;
    repeat (5) tick();
    check("busy_in_glitch", int'(busy_o), 1);
    repeat (5) tick();
    rx = 1'b1;
    repeat (C / 2 + 4) tick();
    check("glitch_idle", int'(busy_o), 0);
    idle(2 * C);

    // Framing error followed by a long break, then a good byte.
    push(1'b1, 8'h3C);
    send_bits(8'h3C, 1'b0, 3300, 1000);
    repeat (40 * C) tick();
    check("busy_in_break", int'(busy_o), 1);
    drain(10);
    check("data_kept_after_ferr", int'(data_o), int'(model_data));
    rx = 1'b1;
    idle(2 * C);
    check("busy_after_break", int'(busy_o), 0);
    push(1'b0, 8'h81);
    send_bits(8'h81, 1'b1, 3300, 1000);
    drain(LAT + 100);

    // Reset during bit 4 of a frame: no pulse, data cleared, next byte ok.
    idle(20);
    send_bits(8'h96, 1'b1, 3300, 5 * C + 10);
    rx    = 1'b1;
    rst_n = 1'b0;
    model_data = 8'h00;
    repeat (3) tick();
    check("midframe_rst_busy", int'(busy_o), 0);
    check("midframe_rst_data", int'(data_o), 0);
    rst_n = 1'b1;
    idle(2 * C);
    check("after_rst_busy", int'(busy_o), 0);
    push(1'b0, 8'h12);
    send_bits(8'h12, 1'b1, 3300, 1000);
    drain(LAT + 100);

    idle(50);
    check("final_queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- 8N1 UART receiver sitting directly between the board's `uart_txd_in` pin and the debug core's byte-level bridge.
- Synchronises the asynchronous serial line and samples each bit at mid-period using a baud counter.
- Emits each received byte with a one-cycle valid strobe; reports framing errors separately.
- Consumer is the bridge's byte input; there is no backpressure (a byte is presented once).

Parameters:
- CLOCKS_PER_BAUD, 33, clk cycles per bit period. Legal range ≥ 4. The default is 100 MHz / 3 Mbaud, rounded.
- SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser. Legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  raw serial line; idles high; asynchronous to clk.
- data_o  output  8  last correctly framed byte, LSB received first.
- valid_o  output  1  one-cycle pulse; data_o holds a new byte.
- frame_err_o  output  1  one-cycle pulse; stop bit was sampled low.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Synchroniser flops are set to 1.
  - State goes to IDLE; baud counter and bit index are cleared.
  - data_o = 0x00, valid_o = 0, frame_err_o = 0, busy_o = 0.
  - Reset asserted mid-frame discards the partial byte with no pulse. Reception restarts at the next falling edge after release.
- Synchroniser:
  - rx passes through SYNC_STAGES flops; all logic uses only the synchronised value `rxs`.
- Baud counter:
  - Width is ceil(log2(CLOCKS_PER_BAUD)).
  - Decrements once per clk; a "tick" occurs in a cycle where the counter equals 0.
  - On a tick the counter reloads CLOCKS_PER_BAUD-1 unless the FSM specifies a different load.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when `rxs`==0, load counter = floor(CLOCKS_PER_BAUD/2)-1 and go to START.
  - START (tick = mid start bit):
    - If `rxs`==1 it is a glitch: go to IDLE with no output.
    - Otherwise clear the bit index and go to DATA.
  - DATA: on each tick shift `rxs` into bit[index] (LSB first) and increment the index. After the tick that captures bit 7, go to STOP.
  - STOP (tick = mid stop bit):
    - If `rxs`==1: register the shift register into data_o, pulse valid_o, go to IDLE.
    - If `rxs`==0: pulse frame_err_o, leave data_o unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay while `rxs`==0 (break condition); go to IDLE once `rxs`==1. No further pulses occur during a break.
- Latency:
  - Let edge E be the first posedge at which the first synchroniser flop captures the start bit's 0.
  - With SYNC_STAGES=2, valid_o is high for exactly the single cycle after posedge E + 2 + floor(C/2) + 9·C, where C = CLOCKS_PER_BAUD.
  - frame_err_o has identical timing.
- Back-to-back frames:
  - The FSM returns to IDLE at mid stop bit, so a start bit immediately following the stop bit is caught.
  - Receiver clock up to ±2% off the sender's rate is tolerated.
- Mutual exclusion: valid_o and frame_err_o are never high in the same cycle. Neither pulse lasts longer than one cycle.
- busy_o is combinational from state (state != IDLE).

Test Plan:
1. Reset, then send 0x55 at C=33 → exactly one valid_o pulse, at the latency formula cycle ±0; data_o=0x55; busy_o low again afterwards.
2. Send 0x00, 0xFF, 0xA3 back-to-back with no idle gap → three valid_o pulses spaced 10·C=330 cycles apart; data_o values 0x00, 0xFF, 0xA3; no frame_err_o.
3. Drive a 10-cycle low glitch on rx → no valid_o and no frame_err_o; state back in IDLE within C/2+4 cycles.
4. Send 0x3C with the stop bit forced low, then hold rx low for 40·C → a single frame_err_o pulse; data_o keeps its previous value; after rx returns high, 0x81 is received correctly.
5. Assert rst_n low during bit 4 of 0x96 for 3 cycles, then send 0x12 → no pulse for the aborted frame; 0x12 is received correctly.
6. Send 0xC5 with the sender 2% fast, then 2% slow (C=33) → valid_o with data_o=0xC5 in both cases.
